// File: rtl/rvs192_pp_elastic_stage_pkg.sv
// Shared types and limits for the rvs192 elastic pipeline stage.
// Optional zero-latency pass-through is selected with the RVS192_PP_BYPASS_EN macro.
package rvs192_pp_elastic_stage_pkg;

    parameter int PP_MAX_DEPTH = 8;

    typedef enum logic [1:0] {
        PP_EMPTY,
        PP_PARTIAL,
        PP_FULL
    } pp_stage_state_type;

    typedef struct packed {
        logic valid;
        logic ready;
        logic flush;
    } pp_hs_type;

    // Buffers are not power-of-two sized, so pointers wrap on an explicit compare.
    function automatic int unsigned pp_ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/rvs192_pp_elastic_stage_buf.sv
// DEPTH x PAYLOAD_W storage for the elastic stage: one write port, one asynchronous read port.
// Contents clear on reset; a flush leaves them untouched.
module rvs192_pp_stage_buf #(
    parameter int PAYLOAD_W = 32,
    parameter int DEPTH     = 2,
    parameter int ADDR_W    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we_i,
    input  logic [ADDR_W-1:0]    waddr_i,
    input  logic [PAYLOAD_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0]    raddr_i,
    output logic [PAYLOAD_W-1:0] rdata_o
);

    logic [PAYLOAD_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rvs192_pp_elastic_stage.sv
// Elastic in-order pipeline register with valid/ready handshakes, flush and occupancy reporting.
// Define RVS192_PP_BYPASS_EN to forward input straight to output when the stage is empty.
module rvs192_pp_elastic_stage
    import rvs192_pp_elastic_stage_pkg::*;
#(
    parameter int PAYLOAD_W = 32,
    parameter int DEPTH     = 2,
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [PAYLOAD_W-1:0] in_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [PAYLOAD_W-1:0] out_data_o,
    output logic [CNT_W-1:0]     count_o,
    output logic                 full_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (DEPTH < 1 || DEPTH > PP_MAX_DEPTH) begin : g_depth_check
        $error("rvs192_pp_elastic_stage: DEPTH must be within 1..PP_MAX_DEPTH");
    end

    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    pp_stage_state_type   state;
    pp_hs_type            in_hs, out_hs;
    logic                 bypass;
    logic                 push, pop;
    logic                 store_we, store_re;
    logic [PAYLOAD_W-1:0] buf_rdata;

    always_comb begin
        if (count_q == '0) begin
            state = PP_EMPTY;
        end else if (count_q == CNT_W'(DEPTH)) begin
            state = PP_FULL;
        end else begin
            state = PP_PARTIAL;
        end
    end

`ifdef RVS192_PP_BYPASS_EN
    assign bypass = (state == PP_EMPTY) && in_valid_i && out_ready_i && !flush_i;
`else
    assign bypass = 1'b0;
`endif

    // in_ready deliberately ignores out_ready: a full stage refuses even while it is being drained.
    always_comb begin
        in_hs.valid  = in_valid_i;
        in_hs.ready  = (state != PP_FULL) && !flush_i;
        in_hs.flush  = flush_i;
        out_hs.valid = bypass || ((state != PP_EMPTY) && !flush_i);
        out_hs.ready = out_ready_i;
        out_hs.flush = flush_i;
    end

    assign push     = in_hs.valid && in_hs.ready && !in_hs.flush;
    assign pop      = out_hs.valid && out_hs.ready && !out_hs.flush;
    assign store_we = push && !bypass;
    assign store_re = pop && !bypass;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (store_we) begin
                wr_ptr_d = PTR_W'(pp_ptr_inc(32'(wr_ptr_q), DEPTH));
            end
            if (store_re) begin
                rd_ptr_d = PTR_W'(pp_ptr_inc(32'(rd_ptr_q), DEPTH));
            end
            case ({store_we, store_re})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    rvs192_pp_stage_buf #(
        .PAYLOAD_W (PAYLOAD_W),
        .DEPTH     (DEPTH),
        .ADDR_W    (PTR_W)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .we_i    (store_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (in_data_i),
        .raddr_i (rd_ptr_q),
        .rdata_o (buf_rdata)
    );

    assign in_ready_o  = in_hs.ready;
    assign out_valid_o = out_hs.valid;
    assign out_data_o  = bypass ? in_data_i : buf_rdata;
    assign count_o     = count_q;
    assign full_o      = (state == PP_FULL);

endmodule

// File: tb/tb_rvs192_pp_elastic_stage.sv
// Directed bench for rvs192_pp_elastic_stage using a DEPTH=2 and a DEPTH=3 instance.
// Expectations follow RVS192_PP_BYPASS_EN when it is defined for the build.
module tb_rvs192_pp_elastic_stage;

`ifdef RVS192_PP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk;
    logic       rst;

    logic       d2Flush, d2InValid, d2InReady, d2OutValid, d2OutReady, d2Full;
    logic [7:0] d2InData, d2OutData;
    logic [1:0] d2Count;

    logic       d3Flush, d3InValid, d3InReady, d3OutValid, d3OutReady, d3Full;
    logic [7:0] d3InData, d3OutData;
    logic [1:0] d3Count;

    int nAsserts = 0;
    int nFails   = 0;

    rvs192_pp_elastic_stage #(.PAYLOAD_W(8), .DEPTH(2)) u_dut2 (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (d2Flush),
        .in_valid_i  (d2InValid),
        .in_ready_o  (d2InReady),
        .in_data_i   (d2InData),
        .out_valid_o (d2OutValid),
        .out_ready_i (d2OutReady),
        .out_data_o  (d2OutData),
        .count_o     (d2Count),
        .full_o      (d2Full)
    );

    rvs192_pp_elastic_stage #(.PAYLOAD_W(8), .DEPTH(3)) u_dut3 (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (d3Flush),
        .in_valid_i  (d3InValid),
        .in_ready_o  (d3InReady),
        .in_data_i   (d3InData),
        .out_valid_o (d3OutValid),
        .out_ready_i (d3OutReady),
        .out_data_o  (d3OutData),
        .count_o     (d3Count),
        .full_o      (d3Full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input int which, input logic v, input logic [7:0] d,
                                 input logic r, input logic f);
        if (which == 2) begin
            d2InValid = v; d2InData = d; d2OutReady = r; d2Flush = f;
        end else begin
            d3InValid = v; d3InData = d; d3OutReady = r; d3Flush = f;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nAsserts++;
        assert (observed === expected) else begin
            nFails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic stepClock(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(2, 1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(3, 1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        checkOutput("por_count", d2Count, 0);
        checkOutput("por_valid", d2OutValid, 0);
        checkOutput("por_data", d2OutData, 0);
        checkOutput("por_ready", d2InReady, 1);
        checkOutput("por_full", d2Full, 0);
        stepClock(2);
        rst = 1'b0;

        $display("[TB] fill/drain DEPTH=2");
        applyStimulus(2, 1'b1, 8'hA1, 1'b0, 1'b0);
        #1;
        checkOutput("fill_ready0", d2InReady, 1);
        checkOutput("fill_novalid0", d2OutValid, 0);
        stepClock(1);
        checkOutput("fill_count1", d2Count, 1);
        checkOutput("fill_valid1", d2OutValid, 1);
        checkOutput("fill_head1", d2OutData, 8'hA1);
        applyStimulus(2, 1'b1, 8'hB2, 1'b0, 1'b0);
        stepClock(1);
        checkOutput("fill_count2", d2Count, 2);
        checkOutput("fill_full", d2Full, 1);
        checkOutput("fill_notready", d2InReady, 0);
        checkOutput("fill_head2", d2OutData, 8'hA1);
        applyStimulus(2, 1'b0, 8'h00, 1'b1, 1'b0);
        #1;
        checkOutput("drain_head_a1", d2OutData, 8'hA1);
        stepClock(1);
        checkOutput("drain_count1", d2Count, 1);
        checkOutput("drain_head_b2", d2OutData, 8'hB2);
        stepClock(1);
        checkOutput("drain_count0", d2Count, 0);
        checkOutput("drain_novalid", d2OutValid, 0);

        $display("[TB] reset mid-run");
        applyStimulus(2, 1'b1, 8'hC3, 1'b0, 1'b0);
        stepClock(1);
        applyStimulus(2, 1'b1, 8'hD4, 1'b0, 1'b0);
        stepClock(1);
        checkOutput("rst_pre_count", d2Count, 2);
        applyStimulus(2, 1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rst_count", d2Count, 0);
        checkOutput("rst_valid", d2OutValid, 0);
        checkOutput("rst_data", d2OutData, 0);
        checkOutput("rst_ready", d2InReady, 1);
        checkOutput("rst_full", d2Full, 0);
        stepClock(1);
        rst = 1'b0;
        stepClock(1);
        checkOutput("rst_post_count", d2Count, 0);

        $display("[TB] backpressure on full");
        applyStimulus(2, 1'b1, 8'h11, 1'b0, 1'b0);
        stepClock(1);
        applyStimulus(2, 1'b1, 8'h22, 1'b0, 1'b0);
        stepClock(1);
        applyStimulus(2, 1'b1, 8'h33, 1'b1, 1'b0);
        #1;
        checkOutput("bp_refuse", d2InReady, 0);
        checkOutput("bp_valid", d2OutValid, 1);
        checkOutput("bp_head11", d2OutData, 8'h11);
        stepClock(1);
        checkOutput("bp_count1", d2Count, 1);
        checkOutput("bp_head22", d2OutData, 8'h22);
        checkOutput("bp_ready", d2InReady, 1);
        applyStimulus(2, 1'b1, 8'h33, 1'b0, 1'b0);
        stepClock(1);
        checkOutput("bp_count2", d2Count, 2);
        checkOutput("bp_full", d2Full, 1);
        checkOutput("bp_head22b", d2OutData, 8'h22);
        applyStimulus(2, 1'b0, 8'h00, 1'b1, 1'b0);
        stepClock(1);
        checkOutput("bp_head33", d2OutData, 8'h33);
        checkOutput("bp_count1b", d2Count, 1);
        stepClock(1);
        checkOutput("bp_count0", d2Count, 0);
        applyStimulus(2, 1'b0, 8'h00, 1'b0, 1'b0);

        $display("[TB] flush with push DEPTH=3");
        applyStimulus(3, 1'b1, 8'h44, 1'b0, 1'b0);
        stepClock(1);
        applyStimulus(3, 1'b1, 8'h55, 1'b0, 1'b0);
        stepClock(1);
        checkOutput("fl_pre_count", d3Count, 2);
        checkOutput("fl_pre_notfull", d3Full, 0);
        applyStimulus(3, 1'b1, 8'hFF, 1'b0, 1'b1);
        #1;
        checkOutput("fl_noready", d3InReady, 0);
        checkOutput("fl_novalid", d3OutValid, 0);
        stepClock(1);
        applyStimulus(3, 1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        checkOutput("fl_count0", d3Count, 0);
        checkOutput("fl_empty", d3OutValid, 0);
        applyStimulus(3, 1'b1, 8'h77, 1'b0, 1'b1);
        stepClock(1);
        checkOutput("fl_twice_count", d3Count, 0);
        applyStimulus(3, 1'b1, 8'h66, 1'b0, 1'b0);
        #1;
        checkOutput("fl_after_ready", d3InReady, 1);
        stepClock(1);
        checkOutput("fl_after_count", d3Count, 1);
        checkOutput("fl_after_valid", d3OutValid, 1);
        checkOutput("fl_after_head", d3OutData, 8'h66);
        applyStimulus(3, 1'b0, 8'h00, 1'b1, 1'b0);
        stepClock(1);
        checkOutput("fl_drain_count", d3Count, 0);
        checkOutput("fl_drain_valid", d3OutValid, 0);

        $display("[TB] streaming DEPTH=3");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(3, 1'b1, 8'(i), 1'b1, 1'b0);
            stepClock(1);
            checkOutput($sformatf("st_valid_%0d", i), d3OutValid, 1);
            checkOutput($sformatf("st_data_%0d", i), d3OutData, 32'(i));
            checkOutput($sformatf("st_count_%0d", i), d3Count, BYP ? 0 : 1);
        end
        applyStimulus(3, 1'b0, 8'h00, 1'b1, 1'b0);
        stepClock(1);
        checkOutput("st_end_count", d3Count, 0);
        checkOutput("st_end_valid", d3OutValid, 0);

        $display("[TB] empty-stage latency");
        applyStimulus(2, 1'b1, 8'h5A, 1'b1, 1'b0);
        #1;
        checkOutput("lat_same_valid", d2OutValid, BYP ? 1 : 0);
        checkOutput("lat_same_data", d2OutValid ? d2OutData : 8'h00, BYP ? 8'h5A : 8'h00);
        checkOutput("lat_same_count", d2Count, 0);
        stepClock(1);
        applyStimulus(2, 1'b0, 8'h00, 1'b1, 1'b0);
        #1;
        checkOutput("lat_next_count", d2Count, BYP ? 0 : 1);
        checkOutput("lat_next_data", d2OutValid ? d2OutData : 8'h00, BYP ? 8'h00 : 8'h5A);
        stepClock(1);
        checkOutput("lat_end_count", d2Count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
